// File: rtl/y86_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : y86_regfile_wb
// Brief    : SEQ Y86-64 register file (15 x 64b) with write-back destination
//            decode (dstE/dstM) and dual-port commit; M port wins conflicts.
// Revision : 1.0 - initial release
// ============================================================================
module y86_regfile_wb #(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   icode,
    input  logic [3:0]   rA,
    input  logic [3:0]   rB,
    input  logic         cnd,
    input  logic         wb_en,
    input  logic [W-1:0] valE,
    input  logic [W-1:0] valM,
    input  logic [3:0]   srcA,
    input  logic [3:0]   srcB,
    output logic [W-1:0] valA,
    output logic [W-1:0] valB,
    output logic [3:0]   dstE,
    output logic [3:0]   dstM,
    input  logic [3:0]   dbg_sel,
    output logic [W-1:0] dbg_val
);

    localparam logic [3:0] c_RNONE   = 4'hF;
    localparam logic [3:0] c_RSP     = 4'h4;
    localparam logic [3:0] c_IRRMOVQ = 4'h2;
    localparam logic [3:0] c_IIRMOVQ = 4'h3;
    localparam logic [3:0] c_IMRMOVQ = 4'h5;
    localparam logic [3:0] c_IOPQ    = 4'h6;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHQ  = 4'hA;
    localparam logic [3:0] c_IPOPQ   = 4'hB;

    logic [W-1:0] r_regs [NREG];

    // Unmatched selects (including RNONE) fall through to zero.
    function automatic logic [W-1:0] f_read(input logic [3:0] sel);
        f_read = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel == 4'(i)) f_read = r_regs[i];
        end
    endfunction

    always_comb begin
        dstE = c_RNONE;
        dstM = c_RNONE;
        case (icode)
            c_IRRMOVQ:                             dstE = cnd ? rB : c_RNONE;
            c_IIRMOVQ, c_IOPQ:                     dstE = rB;
            c_ICALL, c_IRET, c_IPUSHQ, c_IPOPQ:    dstE = c_RSP;
            default:                               dstE = c_RNONE;
        endcase
        if (icode == c_IMRMOVQ || icode == c_IPOPQ) dstM = rA;
    end

    always_comb begin
        valA    = f_read(srcA);
        valB    = f_read(srcB);
        dbg_val = f_read(dbg_sel);
    end

    // M port is tested first so that popq %rsp commits the loaded value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (wb_en) begin
            for (int i = 0; i < NREG; i++) begin
                if (dstM == 4'(i))      r_regs[i] <= valM;
                else if (dstE == 4'(i)) r_regs[i] <= valE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_y86_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_regfile_wb
// Brief    : Self-checking bench for y86_regfile_wb: directed vector table,
//            multi-cycle corner sequences and randomized model comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y86_regfile_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  icode, rA, rB, srcA, srcB, dbg_sel, dstE, dstM;
    logic        cnd, wb_en;
    logic [63:0] valE, valM, valA, valB, dbg_val;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    y86_regfile_wb #(.NREG(15), .W(64)) dut (
        .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .wb_en(wb_en), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
        .valA(valA), .valB(valB), .dstE(dstE), .dstM(dstM),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val)
    );

    typedef struct {
        logic [3:0]  icode, ra, rb;
        logic        cnd, en;
        logic [63:0] vale, valm;
        logic [3:0]  xde, xdm;
        logic [3:0]  rda;
        logic [63:0] xa;
        logic [3:0]  rdb;
        logic [63:0] xb;
    } vec_t;

    vec_t tbl [10];

    // Reference state: architectural registers as a plain array.
    logic [63:0] m [0:14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] b, input logic c);
        if (ic == 4'd2) return c ? b : 4'd15;
        if (ic == 4'd3 || ic == 4'd6) return b;
        if (ic >= 4'd8 && ic <= 4'd11) return 4'd4;
        return 4'd15;
    endfunction

    function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] a);
        return (ic == 4'd5 || ic == 4'd11) ? a : 4'd15;
    endfunction

    function automatic logic [63:0] m_rd(input logic [3:0] id);
        return (id == 4'd15) ? 64'd0 : m[id];
    endfunction

    initial begin
        logic [3:0] de, dm;
        tbl[0] = '{4'd3, 4'd15, 4'd2, 1'b0, 1'b1, 64'h1122334455667788, 64'h0,
                   4'd2, 4'd15, 4'd2, 64'h1122334455667788, 4'd3, 64'h0};
        tbl[1] = '{4'd2, 4'd15, 4'd5, 1'b0, 1'b1, 64'hAA, 64'h0,
                   4'd15, 4'd15, 4'd5, 64'h0, 4'd2, 64'h1122334455667788};
        tbl[2] = '{4'd2, 4'd15, 4'd5, 1'b1, 1'b1, 64'hAA, 64'h0,
                   4'd5, 4'd15, 4'd5, 64'hAA, 4'd15, 64'h0};
        tbl[3] = '{4'd11, 4'd4, 4'd15, 1'b0, 1'b1, 64'h108, 64'hDEAD,
                   4'd4, 4'd4, 4'd4, 64'hDEAD, 4'd5, 64'hAA};
        tbl[4] = '{4'd11, 4'd3, 4'd15, 1'b0, 1'b1, 64'h200, 64'h55,
                   4'd4, 4'd3, 4'd4, 64'h200, 4'd3, 64'h55};
        tbl[5] = '{4'd6, 4'd0, 4'd1, 1'b0, 1'b0, 64'h7, 64'h0,
                   4'd1, 4'd15, 4'd1, 64'h0, 4'd4, 64'h200};
        tbl[6] = '{4'd12, 4'd1, 4'd1, 1'b1, 1'b1, 64'hBAD, 64'hBAD,
                   4'd15, 4'd15, 4'd1, 64'h0, 4'd0, 64'h0};
        tbl[7] = '{4'd5, 4'd14, 4'd15, 1'b0, 1'b1, 64'h1, 64'h99,
                   4'd15, 4'd14, 4'd14, 64'h99, 4'd15, 64'h0};
        tbl[8] = '{4'd8, 4'd15, 4'd15, 1'b0, 1'b1, 64'h300, 64'h0,
                   4'd4, 4'd15, 4'd4, 64'h300, 4'd3, 64'h55};
        tbl[9] = '{4'd0, 4'd7, 4'd7, 1'b1, 1'b1, 64'h77, 64'h77,
                   4'd15, 4'd15, 4'd7, 64'h0, 4'd14, 64'h99};

        reset = 1'b1; icode = 4'd0; rA = 4'd15; rB = 4'd15; cnd = 1'b0; wb_en = 1'b0;
        valE = '0; valM = '0; srcA = 4'd15; srcB = 4'd15; dbg_sel = 4'd15;
        step();
        reset = 1'b0;

        // Fill every register, then clear with reset while a write is pending.
        wb_en = 1'b1; icode = 4'd3;
        for (int i = 0; i < 15; i++) begin
            rB = 4'(i); valE = 64'h0100 + 64'(i);
            step();
        end
        dbg_sel = 4'd3; #1;
        chk("fill_r3", dbg_val, 64'h0103);
        reset = 1'b1; rB = 4'd7; valE = 64'hFF;
        step();
        reset = 1'b0; wb_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            srcA = 4'(i); srcB = 4'(i); dbg_sel = 4'(i); #1;
            chk("reset_valA", valA, 64'h0);
            chk("reset_valB", valB, 64'h0);
            chk("reset_dbg", dbg_val, 64'h0);
        end

        foreach (tbl[k]) begin
            icode = tbl[k].icode; rA = tbl[k].ra; rB = tbl[k].rb; cnd = tbl[k].cnd;
            wb_en = tbl[k].en; valE = tbl[k].vale; valM = tbl[k].valm;
            #1;
            chk($sformatf("v%0d_dstE", k), 64'(dstE), 64'(tbl[k].xde));
            chk($sformatf("v%0d_dstM", k), 64'(dstM), 64'(tbl[k].xdm));
            step();
            srcA = tbl[k].rda; srcB = tbl[k].rdb; #1;
            chk($sformatf("v%0d_valA", k), valA, tbl[k].xa);
            chk($sformatf("v%0d_valB", k), valB, tbl[k].xb);
        end

        // Read-during-write: valB shows the pre-edge value until the edge.
        icode = 4'd6; rB = 4'd1; valE = 64'h7; wb_en = 1'b1; srcB = 4'd1; #1;
        chk("rdw_before", valB, 64'h0);
        step();
        chk("rdw_after", valB, 64'h7);
        // Mid-program reset discards the write in the same cycle.
        reset = 1'b1; rB = 4'd9; valE = 64'h1234; srcA = 4'd9;
        step();
        reset = 1'b0; wb_en = 1'b0; #1;
        chk("midreset_r9", valA, 64'h0);
        chk("midreset_r1", valB, 64'h0);

        for (int i = 0; i < 15; i++) m[i] = '0;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            icode = 4'($urandom_range(0, 15));
            rA = 4'($urandom_range(0, 15));
            rB = 4'($urandom_range(0, 15));
            cnd = 1'($urandom_range(0, 1));
            wb_en = ($urandom_range(0, 7) != 0);
            valE = {$urandom, $urandom};
            valM = {$urandom, $urandom};
            srcA = 4'($urandom_range(0, 15));
            srcB = 4'($urandom_range(0, 15));
            dbg_sel = 4'($urandom_range(0, 15));
            #1;
            de = m_dste(icode, rB, cnd);
            dm = m_dstm(icode, rA);
            chk("rnd_dstE", 64'(dstE), 64'(de));
            chk("rnd_dstM", 64'(dstM), 64'(dm));
            chk("rnd_valA", valA, m_rd(srcA));
            chk("rnd_valB", valB, m_rd(srcB));
            chk("rnd_dbg", dbg_val, m_rd(dbg_sel));
            if (reset) begin
                for (int i = 0; i < 15; i++) m[i] = '0;
            end else if (wb_en) begin
                if (de != 4'd15) m[de] = valE;
                if (dm != 4'd15) m[dm] = valM;
            end
            step();
        end
        reset = 1'b0; wb_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i); #1;
            chk("final_dbg", dbg_val, m_rd(4'(i)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
